// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if : E-stage HI/LO bus between the pipeline and the multiply/divide unit.
//
// Signals
//   isHILO    pipeline -> mdu  E-stage instruction is a HI/LO-class instruction
//   HILOtype  pipeline -> mdu  4-bit decoder op code (mult, div, mfhi, mthi ...)
//   A, B      pipeline -> mdu  forwarded rs / rt operands
//   req       pipeline -> mdu  exception/interrupt flush of the E-stage op
//   start     mdu -> pipeline  a multi-cycle op is accepted this cycle
//   busy      mdu -> pipeline  a multi-cycle op is in flight (hazard stall)
//   HILO_out  mdu -> pipeline  mfhi / mflo read data
//
// Modports: master = pipeline side (drives the request), slave = the mdu.
// -----------------------------------------------------------------------------
interface mdu_if;
  logic        isHILO;
  logic [3:0]  HILOtype;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] HILO_out;

  modport master (
    output isHILO, HILOtype, A, B, req,
    input  start, busy, HILO_out
  );

  modport slave (
    input  isHILO, HILOtype, A, B, req,
    output start, busy, HILO_out
  );
endinterface

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu : MIPS-style multiply/divide unit owning the HI and LO registers.
//
// Multi-cycle ops (mult, multu, div, divu, madd, maddu, msub, msubu) are
// accepted through 'start', their 64-bit result is computed immediately into
// temp registers and held there while a down-counter models the unit latency.
// HI/LO are written from temp on the edge where busy falls, so earlier mfhi /
// mflo still observe the old values. mthi / mtlo write HI / LO directly.
//
// Ports
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; clears HI, LO, temp, counter and busy
//   bus    mdu_if.slave : isHILO, HILOtype, A, B, req in; start, busy,
//          HILO_out out
//
// Parameters
//   MULT_CYCLES  busy cycles for the multiply family
//   DIV_CYCLES   busy cycles for div / divu
// -----------------------------------------------------------------------------
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Decoder op codes
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      temp_hi_q, temp_hi_d;
  logic [31:0]      temp_lo_q, temp_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic             is_multi;
  logic             is_div;
  logic             is_signed;
  logic             start_w;
  logic [63:0]      a_ext;
  logic [63:0]      b_ext;
  logic [63:0]      product;
  logic [63:0]      acc;
  logic             a_neg;
  logic             b_neg;
  logic [31:0]      a_mag;
  logic [31:0]      b_mag;
  logic [31:0]      q_mag;
  logic [31:0]      r_mag;
  logic [31:0]      quotient;
  logic [31:0]      remainder;
  logic [63:0]      result;

  // Classify the presented op and form the accept strobe. Anything outside
  // the multi-cycle set (including 0 and 13-15) never starts the unit.
  always_comb begin
    is_multi  = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (bus.HILOtype)
      OP_MULT, OP_MADD, OP_MSUB: begin
        is_multi  = 1'b1;
        is_signed = 1'b1;
      end
      OP_MULTU, OP_MADDU, OP_MSUBU: begin
        is_multi  = 1'b1;
      end
      OP_DIV: begin
        is_multi  = 1'b1;
        is_div    = 1'b1;
        is_signed = 1'b1;
      end
      OP_DIVU: begin
        is_multi  = 1'b1;
        is_div    = 1'b1;
      end
      default: begin
        is_multi  = 1'b0;
      end
    endcase
    start_w = bus.isHILO & is_multi & ~bus.req & ~busy_q;
  end

  // Multiply: extending both operands to 64 bits (sign or zero) makes the
  // low 64 bits of a single unsigned product correct for both signednesses.
  always_comb begin
    a_ext   = is_signed ? {{32{bus.A[31]}}, bus.A} : {32'b0, bus.A};
    b_ext   = is_signed ? {{32{bus.B[31]}}, bus.B} : {32'b0, bus.B};
    product = a_ext * b_ext;
    acc     = {hi_q, lo_q};
  end

  // Divide on magnitudes, then restore signs: quotient takes the XOR of the
  // operand signs, remainder takes the dividend's sign. 0x80000000 / -1
  // falls out naturally as quotient 0x80000000, remainder 0.
  always_comb begin
    a_neg     = is_signed & bus.A[31];
    b_neg     = is_signed & bus.B[31];
    a_mag     = a_neg ? (32'd0 - bus.A) : bus.A;
    b_mag     = b_neg ? (32'd0 - bus.B) : bus.B;
    q_mag     = 32'd0;
    r_mag     = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    remainder = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Select the 64-bit value that will land in {HI,LO} at commit. A divide by
  // zero captures the current HI/LO, so the commit leaves them unchanged;
  // HI/LO cannot move while busy, so this snapshot stays valid.
  always_comb begin
    result = acc;
    case (bus.HILOtype)
      OP_MULT, OP_MULTU:   result = product;
      OP_MADD, OP_MADDU:   result = acc + product;
      OP_MSUB, OP_MSUBU:   result = acc - product;
      OP_DIV, OP_DIVU: begin
        if (bus.B != 32'd0) begin
          result = {remainder, quotient};
        end
      end
      default:             result = acc;
    endcase
  end

  // Next-state logic. While busy the counter runs down and the last busy
  // cycle commits temp into HI/LO; new requests and mthi/mtlo are ignored
  // and req has no effect on the op already in flight.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        hi_d   = temp_hi_q;
        lo_d   = temp_lo_q;
      end else begin
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end else if (start_w) begin
      temp_hi_d = result[63:32];
      temp_lo_d = result[31:0];
      cnt_d     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy_d    = 1'b1;
    end else if (bus.isHILO & ~bus.req) begin
      if (bus.HILOtype == OP_MTHI) begin
        hi_d = bus.A;
      end else if (bus.HILOtype == OP_MTLO) begin
        lo_d = bus.A;
      end
    end
  end

  // State registers; reset wins over start, commit and mthi/mtlo.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Outputs: mfhi / mflo read the committed registers only.
  always_comb begin
    bus.start    = start_w;
    bus.busy     = busy_q;
    bus.HILO_out = 32'd0;
    if (bus.HILOtype == OP_MFHI) begin
      bus.HILO_out = hi_q;
    end else if (bus.HILOtype == OP_MFLO) begin
      bus.HILO_out = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu : scoreboard bench for mdu. Each accepted op pushes its expected
// {HI,LO} into a queue; when busy falls the committed value is read back
// through mfhi/mflo and compared against the popped entry.
// -----------------------------------------------------------------------------
module tb_mdu;

  logic clk;
  logic reset;

  mdu_if u_if ();

  mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  int          checkCount = 0;
  int          failCount  = 0;
  logic [63:0] expQ[$];
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Independent reference model of one multi-cycle op using native integer
  // arithmetic; acc is the {HI,LO} value seen when the op starts.
  function automatic logic [63:0] modelOp(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, ua, ub;
    int     ia, ib, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    res = acc;
    case (op)
      4'd1:  res = 64'(sa * sb);
      4'd2:  res = 64'(ua * ub);
      4'd9:  res = acc + 64'(sa * sb);
      4'd10: res = acc + 64'(ua * ub);
      4'd11: res = acc - 64'(sa * sb);
      4'd12: res = acc - 64'(ua * ub);
      4'd3: begin
        if (b == 32'd0) begin
          res = acc;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res = {32'h0000_0000, 32'h8000_0000};
        end else begin
          ia  = $signed(a);
          ib  = $signed(b);
          q   = ia / ib;
          r   = ia % ib;
          res = {32'(r), 32'(q)};
        end
      end
      4'd4: begin
        if (b == 32'd0) res = acc;
        else            res = {a % b, a / b};
      end
      default: res = acc;
    endcase
    return res;
  endfunction

  // Read HI and LO through mfhi / mflo within the current cycle.
  task automatic readHiLo(output logic [63:0] v);
    logic [3:0] saved;
    saved           = u_if.HILOtype;
    u_if.HILOtype   = 4'd5;
    #1 v[63:32]     = u_if.HILO_out;
    u_if.HILOtype   = 4'd6;
    #1 v[31:0]      = u_if.HILO_out;
    u_if.HILOtype   = saved;
  endtask

  task automatic checkHiLo(input string tag);
    logic [63:0] v;
    readHiLo(v);
    checkOutput(tag, v, {mHi, mLo});
  endtask

  // Present one E-stage instruction for a single cycle. Called just after a
  // rising edge; checks start before the edge and busy after it.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic reqv, input logic expStart);
    logic [63:0] e;
    u_if.isHILO   = 1'b1;
    u_if.HILOtype = op;
    u_if.A        = a;
    u_if.B        = b;
    u_if.req      = reqv;
    #1 checkOutput({tag, ".start"}, 64'(u_if.start), 64'(expStart));
    if (expStart) begin
      e   = modelOp(op, a, b, {mHi, mLo});
      expQ.push_back(e);
      mHi = e[63:32];
      mLo = e[31:0];
    end else if (!reqv && !u_if.busy) begin
      if (op == 4'd7) mHi = a;
      if (op == 4'd8) mLo = a;
    end
    @(posedge clk);
    #1;
    u_if.isHILO   = 1'b0;
    u_if.HILOtype = 4'd0;
    u_if.req      = 1'b0;
    checkOutput({tag, ".busy"}, 64'(u_if.busy), 64'(expStart));
  endtask

  // Count busy cycles (bounded), then compare the commit with the scoreboard.
  task automatic waitDone(input string tag, input int expCycles, input logic reqDuring);
    int          cycles;
    logic [63:0] v;
    logic [63:0] e;
    cycles = 1;
    while (u_if.busy && cycles < 100) begin
      u_if.req = reqDuring;
      @(posedge clk);
      #1;
      if (u_if.busy) cycles++;
    end
    u_if.req      = 1'b0;
    u_if.isHILO   = 1'b0;
    u_if.HILOtype = 4'd0;
    checkOutput({tag, ".cycles"}, 64'(cycles), 64'(expCycles));
    e = (expQ.size() > 0) ? expQ.pop_front() : 64'hx;
    readHiLo(v);
    checkOutput({tag, ".hilo"}, v, e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] v;
    logic [3:0]  ops[8];
    int          cycles;
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12};

    u_if.isHILO   = 1'b0;
    u_if.HILOtype = 4'd0;
    u_if.A        = 32'd0;
    u_if.B        = 32'd0;
    u_if.req      = 1'b0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst.busy", 64'(u_if.busy), 64'd0);
    checkOutput("rst.start", 64'(u_if.start), 64'd0);
    checkHiLo("rst.hilo");

    $display("[TB] mult / multu");
    applyStimulus("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
    checkOutput("mult.start_once", 64'(u_if.start), 64'd0);
    waitDone("mult", 5, 1'b0);
    checkOutput("mult.const", {mHi, mLo}, 64'hFFFF_FFFF_FFFF_FFFA);
    applyStimulus("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
    waitDone("multu", 5, 1'b0);
    checkOutput("multu.const", {mHi, mLo}, 64'h0000_0002_FFFF_FFFA);

    $display("[TB] div / divu");
    applyStimulus("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    waitDone("div", 10, 1'b0);
    checkOutput("div.const", {mHi, mLo}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus("divu0", 4'd4, 32'd7, 32'd0, 1'b0, 1'b1);
    waitDone("divu0", 10, 1'b0);

    $display("[TB] mthi / mtlo / madd / msubu");
    applyStimulus("mthi", 4'd7, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    applyStimulus("mtlo", 4'd8, 32'h0000_0001, 32'd0, 1'b0, 1'b0);
    checkHiLo("mtx.hilo");
    applyStimulus("madd", 4'd9, 32'd2, 32'd3, 1'b0, 1'b1);
    waitDone("madd", 5, 1'b0);
    checkOutput("madd.const", {mHi, mLo}, 64'h1234_5678_0000_0007);
    applyStimulus("msubu", 4'd12, 32'd1, 32'd8, 1'b0, 1'b1);
    waitDone("msubu", 5, 1'b0);
    checkOutput("msubu.const", {mHi, mLo}, 64'h1234_5677_FFFF_FFFF);

    $display("[TB] div overflow corner");
    applyStimulus("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    waitDone("divovf", 10, 1'b0);

    $display("[TB] req flush and req during busy");
    applyStimulus("multreq", 4'd1, 32'd5, 32'd7, 1'b1, 1'b0);
    checkHiLo("multreq.hilo");
    applyStimulus("divreq", 4'd3, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b1);
    waitDone("divreq", 10, 1'b1);

    $display("[TB] undefined op and mthi while busy");
    applyStimulus("op13", 4'd13, 32'hAAAA_AAAA, 32'd1, 1'b0, 1'b0);
    checkHiLo("op13.hilo");
    applyStimulus("mtbusy", 4'd11, 32'd3, 32'd4, 1'b0, 1'b1);
    u_if.isHILO   = 1'b1;
    u_if.HILOtype = 4'd7;
    u_if.A        = 32'hDEAD_BEEF;
    waitDone("mtbusy", 5, 1'b0);
    nextCycle();
    checkHiLo("mtbusy.after");

    $display("[TB] second op presented while busy");
    applyStimulus("b2b1", 4'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
    u_if.isHILO   = 1'b1;
    u_if.HILOtype = 4'd2;
    u_if.A        = 32'hFFFF_FFFF;
    u_if.B        = 32'hFFFF_FFFF;
    cycles = 1;
    while (u_if.busy && cycles < 100) begin
      checkOutput("b2b.start_blocked", 64'(u_if.start), 64'd0);
      nextCycle();
      if (u_if.busy) cycles++;
    end
    checkOutput("b2b1.cycles", 64'(cycles), 64'd5);
    checkOutput("b2b2.start", 64'(u_if.start), 64'd1);
    v = (expQ.size() > 0) ? expQ.pop_front() : 64'hx;
    expQ.push_back(modelOp(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {mHi, mLo}));
    {mHi, mLo} = expQ[expQ.size() - 1];
    nextCycle();
    u_if.isHILO   = 1'b0;
    u_if.HILOtype = 4'd0;
    checkOutput("b2b2.busy", 64'(u_if.busy), 64'd1);
    begin
      logic [63:0] r;
      readHiLo(r);
      checkOutput("b2b1.hilo_precommit", r, v);
    end
    waitDone("b2b2", 5, 1'b0);

    $display("[TB] random back-to-back ops");
    for (int i = 0; i < 8; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      applyStimulus("rand", op, a, b, 1'b0, 1'b1);
      waitDone("rand", (op == 4'd3 || op == 4'd4) ? 10 : 5, 1'b0);
    end

    $display("[TB] reset in third busy cycle");
    applyStimulus("rstbusy", 4'd1, 32'd9, 32'd9, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    expQ.delete();
    mHi = 32'd0;
    mLo = 32'd0;
    checkOutput("rstbusy.busy", 64'(u_if.busy), 64'd0);
    checkHiLo("rstbusy.hilo");
    repeat (8) nextCycle();
    checkOutput("rstbusy.busy_later", 64'(u_if.busy), 64'd0);
    checkHiLo("rstbusy.hilo_later");

    $display("[TB] reset priority over mthi");
    applyStimulus("mthi2", 4'd7, 32'h0000_00AA, 32'd0, 1'b0, 1'b0);
    checkHiLo("mthi2.hilo");
    reset         = 1'b1;
    u_if.isHILO   = 1'b1;
    u_if.HILOtype = 4'd7;
    u_if.A        = 32'h0000_0055;
    nextCycle();
    reset         = 1'b0;
    u_if.isHILO   = 1'b0;
    u_if.HILOtype = 4'd0;
    mHi = 32'd0;
    mLo = 32'd0;
    checkHiLo("rstprio.hilo");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu.
REQ-002 DIV_CYCLES, 10, busy cycles for div/divu.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 isHILO  input  1  E-stage instruction is a HI/LO-class instruction.
REQ-006 HILOtype  input  4  operation code, matching the decoder's encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu.
REQ-007 A  input  32  forwarded rs operand.
REQ-008 B  input  32  forwarded rt operand.
REQ-009 req  input  1  exception/interrupt flush; suppresses any E-stage HI/LO action this cycle.
REQ-010 start  output  1  combinational; a multi-cycle operation is accepted this cycle.
REQ-011 busy  output  1  registered; a multi-cycle operation is in flight.
REQ-012 HILO_out  output  32  combinational; HI when HILOtype=5, LO when HILOtype=6, else 0.

Function
REQ-013 start SHALL equal isHILO & HILOtype in {1,2,3,4,9,10,11,12} & !req & !busy.
REQ-014 On start, operands SHALL be latched, the 64-bit result computed into temp registers, and a down-counter loaded with MULT_CYCLES or DIV_CYCLES.
REQ-015 busy SHALL rise the cycle after start and stay high for exactly the loaded count, then fall.
REQ-016 HI/LO SHALL be written from temp on the same edge where busy falls, so HILO_out reflects the result in the first cycle busy is low.
REQ-017 mult: {HI,LO} = signed A*B; multu: unsigned A*B, full 64 bits.
REQ-018 madd/maddu: {HI,LO} = {HI,LO} + signed/unsigned A*B; msub/msubu: subtract; 64-bit wrap-around, no overflow flag. The {HI,LO} operand is sampled at start.
REQ-019 div: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign; divu: unsigned.
REQ-020 div/divu with B=0 SHALL still occupy DIV_CYCLES busy cycles and leave HI/LO unchanged.
REQ-021 div with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 mthi/mtlo SHALL write A to HI/LO on the next edge when isHILO & !req & !busy; they are ignored while busy.
REQ-023 A multi-cycle op presented while busy SHALL be ignored (start=0). The hazard unit stalls it until busy is low.
REQ-024 req SHALL NOT abort an in-flight operation; the older instruction completes and commits normally.
REQ-025 mfhi/mflo while busy SHALL return the pre-commit HI/LO. The hazard unit is responsible for stalling them.
REQ-026 HILOtype values 0 and 13-15 SHALL cause no state change.

Reset
REQ-027 With reset high at an edge, HI, LO, temp registers and counter SHALL clear to 0, and busy SHALL be 0 the next cycle.
REQ-028 Reset SHALL take priority over start, commit and mthi/mtlo in the same cycle.
REQ-029 Reset during busy SHALL discard the pending result, and HI/LO SHALL read 0 afterwards.

Verification
REQ-030 mult A=0xFFFFFFFE, B=3 -> start=1 for 1 cycle, busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x2, LO=0xFFFFFFFA.
REQ-031 div A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> HI/LO unchanged after 10 busy cycles.
REQ-032 mthi 0x12345678, mtlo 0x1 -> next cycle mfhi gives 0x12345678, mflo gives 1. madd A=2, B=3 -> {HI,LO}=0x12345678_00000007. msubu A=1, B=8 -> LO=0xFFFFFFFF, HI=0x12345677.
REQ-033 mult issued with req=1 -> start=0, busy stays 0, HI/LO unchanged. req=1 during an in-flight div -> result still commits on schedule.
REQ-034 Second mult presented while busy -> ignored until busy falls, then accepted with start=1. Back-to-back operations produce correct sequential results.
REQ-035 Reset asserted in the 3rd busy cycle of a mult -> busy=0, HI=LO=0, no later commit.
